// File: rtl/hazard_forward_ctrl.sv
// Load-use stall, branch flush and EX operand forwarding control for a 5-stage pipeline.
// Define HFU_STATS_EN to get saturating stall-cycle and flush counters.
module hazard_forward_ctrl #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_dst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          branch_taken,
    output logic          pc_write,
    output logic          if_id_write,
    output logic          id_ex_bubble,
    output logic          flush_if_id,
    output logic          flush_id_ex,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic [15:0]   stall_cycles,
    output logic [15:0]   flush_count
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] dst;
        logic          regwrite;
        logic          memread;
    } stage_t;

    typedef enum logic [1:0] {IDLE, STALL, FLUSH} state_t;

    localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

    stage_t     ex_reg, mem_reg, wb_reg;
    state_t     state_reg;
    logic [1:0] cnt_reg;
    logic       branch, hazard, stall;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src,
                                           input stage_t mem_s, input stage_t wb_s);
        if (mem_s.valid && mem_s.regwrite && mem_s.dst != '0 && mem_s.dst == src)
            return 2'b10;
        else if (wb_s.valid && wb_s.regwrite && wb_s.dst != '0 && wb_s.dst == src)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // A branch seen while reset is held must not disturb the reset output values.
    always_comb begin
        branch = branch_taken & rst_n;
        hazard = id_valid && ex_reg.valid && ex_reg.memread && ex_reg.dst != '0 &&
                 (ex_reg.dst == id_rs || ex_reg.dst == id_rt) && state_reg != FLUSH;
        stall  = !branch && ((state_reg == STALL && cnt_reg != 2'd0) || hazard);
        pc_write     = !stall;
        if_id_write  = !stall;
        id_ex_bubble = branch || stall;
        flush_if_id  = branch;
        flush_id_ex  = branch;
        fwd_a = ex_reg.valid ? fwd_sel(ex_reg.rs, mem_reg, wb_reg) : 2'b00;
        fwd_b = ex_reg.valid ? fwd_sel(ex_reg.rt, mem_reg, wb_reg) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
        end else if (branch) begin
            state_reg <= FLUSH;
            cnt_reg   <= 2'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (hazard) begin
                        state_reg <= STALL;
                        cnt_reg   <= CNT_INIT;
                    end
                end
                STALL: begin
                    if (cnt_reg != 2'd0) begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end else if (hazard) begin
                        cnt_reg <= CNT_INIT;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg  <= '0;
            mem_reg <= '0;
            wb_reg  <= '0;
        end else begin
            ex_reg  <= id_ex_bubble ? '0 :
                       {id_valid, id_rs, id_rt, id_dst, id_regwrite, id_memread};
            mem_reg <= ex_reg;
            wb_reg  <= mem_reg;
        end
    end

    // WB only ever sources a forward, so its source fields are carried but not read.
    logic unused_wb;
    assign unused_wb = ^{wb_reg.rs, wb_reg.rt, wb_reg.memread};

`ifdef HFU_STATS_EN
    logic [15:0] stall_cycles_reg, flush_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_reg <= 16'd0;
            flush_count_reg  <= 16'd0;
        end else begin
            if (!pc_write && stall_cycles_reg != 16'hFFFF)
                stall_cycles_reg <= stall_cycles_reg + 16'd1;
            if (branch && flush_count_reg != 16'hFFFF)
                flush_count_reg <= flush_count_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`else
    assign stall_cycles = 16'd0;
    assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench: LOAD_LAT = 1, 2, 3 instances share a stimulus bus; only the selected one sees live traffic.
module tb_hazard_forward_ctrl;
    localparam int AW = 5;
    // Expected vector layout: {pc_write, if_id_write, bubble, flush_if_id, flush_id_ex, fwd_a, fwd_b}
    localparam logic [8:0] N  = 9'b11000_00_00;
    localparam logic [8:0] S  = 9'b00100_00_00;
    localparam logic [8:0] BR = 9'b11111_00_00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          b_valid, b_rw, b_mr, b_br;
    logic [AW-1:0] b_rs, b_rt, b_dst;
    int            cur_sel;

    logic [2:0]  pcw, ifw, bub, fi, fe;
    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic [15:0] sc [3];
    logic [15:0] fc [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            hazard_forward_ctrl #(.AW(AW), .LOAD_LAT(gi + 1)) dut (
                .clk          (clk),
                .rst_n        (rst_n),
                .id_valid     (b_valid && (cur_sel == gi)),
                .id_rs        (b_rs),
                .id_rt        (b_rt),
                .id_dst       (b_dst),
                .id_regwrite  (b_rw),
                .id_memread   (b_mr),
                .branch_taken (b_br && (cur_sel == gi)),
                .pc_write     (pcw[gi]),
                .if_id_write  (ifw[gi]),
                .id_ex_bubble (bub[gi]),
                .flush_if_id  (fi[gi]),
                .flush_id_ex  (fe[gi]),
                .fwd_a        (fa[gi]),
                .fwd_b        (fb[gi]),
                .stall_cycles (sc[gi]),
                .flush_count  (fc[gi])
            );
        end
    endgenerate

    typedef struct {
        int         sel;
        logic [8:0] exp;
        int         id;
    } item_t;

    item_t q[$];
    int vectors = 0;
    int miscompares = 0;
    int vec_id = 0;

    function automatic logic [8:0] obs(input int s);
        return {pcw[s], ifw[s], bub[s], fi[s], fe[s], fa[s], fb[s]};
    endfunction

    function automatic logic [8:0] f(input logic [8:0] base, input logic [1:0] a, input logic [1:0] b);
        return base | {5'b0, a, b};
    endfunction

    function automatic int es(input int n);
`ifdef HFU_STATS_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // One clock of stimulus: drive just after the active edge, queue what the DUT must show.
    task automatic cyc(input int s, input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] dst, input logic rw, input logic mr, input logic br,
                       input logic [8:0] exp);
        cur_sel = s; b_valid = v; b_rs = rs; b_rt = rt; b_dst = dst;
        b_rw = rw; b_mr = mr; b_br = br;
        q.push_back('{s, exp, vec_id});
        vec_id++;
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input int s, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] dst, input logic rw, input logic mr, input logic [8:0] exp);
        cyc(s, 1'b1, rs, rt, dst, rw, mr, 1'b0, exp);
    endtask

    task automatic nop(input int s, input logic [8:0] exp);
        cyc(s, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic chk_stats(input int s, input int stalls, input int flushes);
        vectors++;
        if (sc[s] !== 16'(es(stalls))) begin
            miscompares++;
            $display("FAIL stall_cycles dut%0d got %0d want %0d", s, sc[s], es(stalls));
        end
        vectors++;
        if (fc[s] !== 16'(es(flushes))) begin
            miscompares++;
            $display("FAIL flush_count dut%0d got %0d want %0d", s, fc[s], es(flushes));
        end
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                it = q.pop_front();
                vectors++;
                if (obs(it.sel) !== it.exp) begin
                    miscompares++;
                    $display("FAIL vec%0d dut%0d got %b want %b", it.id, it.sel, obs(it.sel), it.exp);
                end else begin
                    $display("vec%0d dut%0d ok %b", it.id, it.sel, it.exp);
                end
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; cur_sel = 0;
        b_valid = 1'b0; b_rw = 1'b0; b_mr = 1'b0; b_br = 1'b0;
        b_rs = '0; b_rt = '0; b_dst = '0;
        repeat (2) @(posedge clk);
        #1;
        // Held in reset: a branch and a live instruction must not move the outputs.
        cyc(0, 1'b1, 5'd3, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, N);
        nop(0, N);
        rst_n = 1'b1;

        // LOAD_LAT=1: lw r3 ; add r4,r3,r5 -> one stall cycle, then MEM/WB forward on rs
        ins(0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, N);
        ins(0, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, S);
        ins(0, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, N);
        nop(0, f(N, 2'b01, 2'b00));

        // add r2 ; sub r6,r2,r2 -> EX/MEM forward on both operands
        ins(0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, N);
        ins(0, 5'd2, 5'd2, 5'd6, 1'b1, 1'b0, N);
        nop(0, f(N, 2'b10, 2'b10));
        // add r2 ; add r7 ; sub r6,r2,r2 -> MEM/WB forward on both operands
        ins(0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, N);
        ins(0, 5'd8, 5'd9, 5'd7, 1'b1, 1'b0, N);
        ins(0, 5'd2, 5'd2, 5'd6, 1'b1, 1'b0, N);
        nop(0, f(N, 2'b01, 2'b01));
        // Two writers of r2 in flight: the younger (MEM) wins
        ins(0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, N);
        ins(0, 5'd10, 5'd11, 5'd2, 1'b1, 1'b0, N);
        ins(0, 5'd2, 5'd5, 5'd6, 1'b1, 1'b0, N);
        nop(0, f(N, 2'b10, 2'b00));

        // r0 load followed by r0 reader: no stall, no forward
        ins(0, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, N);
        ins(0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, N);
        nop(0, N);
        // Matching reader that is not valid: ignored
        ins(0, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, N);
        cyc(0, 1'b0, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, N);
        nop(0, N);
        chk_stats(0, 1, 0);

        // LOAD_LAT=3: hazard through rt -> exactly three stall cycles
        ins(2, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, N);
        ins(2, 5'd5, 5'd3, 5'd4, 1'b1, 1'b0, S);
        ins(2, 5'd5, 5'd3, 5'd4, 1'b1, 1'b0, S);
        ins(2, 5'd5, 5'd3, 5'd4, 1'b1, 1'b0, S);
        ins(2, 5'd5, 5'd3, 5'd4, 1'b1, 1'b0, N);
        nop(2, N);
        chk_stats(2, 3, 0);

        // LOAD_LAT=2: branch in the second stall cycle overrides, one FLUSH cycle, then IDLE
        ins(1, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, N);
        ins(1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, S);
        cyc(1, 1'b1, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, 1'b1, BR);
        nop(1, N);
        nop(1, N);
        chk_stats(1, 1, 1);

        // LOAD_LAT=3: reset dropped between clock edges mid-stall
        ins(2, 5'd1, 5'd0, 5'd3, 1'b1, 1'b1, N);
        ins(2, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, S);
        ins(2, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, S);
        rst_n = 1'b0;
        ins(2, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, N);
        rst_n = 1'b1;
        ins(2, 5'd3, 5'd5, 5'd4, 1'b1, 1'b0, N);
        nop(2, N);
        chk_stats(2, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain pending %0d want 0", q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
